// File: rtl/descriptor_alloc_arbiter.sv
// Descriptor allocation arbiter: prefetches free descriptor addresses
// and hands them round-robin to enqueue pipelines.
module descriptor_alloc_arbiter #(
    parameter int DESCRIPTOR_MEM_ADDR_WIDTH = 12,
    parameter int NUM_REQ                   = 4,
    parameter int PREFETCH_DEPTH            = 4,
    parameter int ACK_HOLDOFF               = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] alloc_addr_i,
    input  logic                                 alloc_valid_i,
    output logic                                 alloc_ack_o,
    input  logic [NUM_REQ-1:0]                   req_i,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic [DESCRIPTOR_MEM_ADDR_WIDTH-1:0] grant_addr_o,
    output logic [$clog2(PREFETCH_DEPTH):0]      fill_level_o,
    output logic [31:0]                          num_grants_o,
    output logic                                 null_addr_err_o
);

    localparam int AW = DESCRIPTOR_MEM_ADDR_WIDTH;
    localparam int PW = $clog2(PREFETCH_DEPTH);
    localparam int FW = PW + 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(ACK_HOLDOFF + 2);

    localparam logic [AW-1:0] NULL_ADDR = '1;

    logic [AW-1:0] mem_q [PREFETCH_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [RW-1:0] rr_q, rr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          found;
    logic [RW-1:0] win;
    logic [RW-1:0] idx;
    logic          grant_vld;
    logic          ack;
    logic          push;
    logic          pop;

    // Round-robin search for the first requester at or after rr_q
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = RW'((int'(rr_q) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant_vld = ~rst_i & (fill_q != '0) & found;
    assign ack       = alloc_valid_i & (hold_q == '0)
                     & (fill_q < FW'(PREFETCH_DEPTH)) & ~rst_i;
    assign push      = ack & (alloc_addr_i != NULL_ADDR);
    assign pop       = grant_vld;

    assign alloc_ack_o     = ack;
    assign grant_o         = grant_vld ? (NUM_REQ'(1) << win) : '0;
    assign grant_addr_o    = mem_q[rd_ptr_q];
    assign fill_level_o    = fill_q;
    assign num_grants_o    = cnt_q;
    assign null_addr_err_o = err_q;

    // Next-state for pointers, fill, holdoff, counters and error flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        rr_d     = rr_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rr_d     = (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            cnt_d    = cnt_q + 32'd1;
        end
        if (push && !pop) begin
            fill_d = fill_q + 1'b1;
        end else if (pop && !push) begin
            fill_d = fill_q - 1'b1;
        end
        if (ack) begin
            hold_d = HW'(ACK_HOLDOFF);
            if (alloc_addr_i == NULL_ADDR) begin
                err_d = 1'b1;
            end
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rr_q     <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rr_q     <= rr_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Prefetch storage; contents need no reset since fill gates use
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= alloc_addr_i;
        end
    end

    a_grant_onehot: assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(grant_o));
    a_grant_req: assert property (
        @(posedge clk_i) disable iff (rst_i) (grant_o & ~req_i) == '0);
    a_fill_max: assert property (
        @(posedge clk_i) disable iff (rst_i)
        fill_q <= FW'(PREFETCH_DEPTH));

endmodule
